// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared constants and elaboration-time helpers for the sequence detector.
package moore_seq_pkg;
   localparam int MAX_PAT_LEN = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // KMP transition: longest pattern prefix that is a suffix of (first k pattern bits ++ b).
   function automatic int next_state(input logic [MAX_PAT_LEN-1:0] pattern, input int len,
                                     input int k, input logic b);
      int best, idx;
      logic ok, sb;
      best = 0;
      for (int j = 1; j <= len && j <= k + 1; j++) begin
         ok = 1'b1;
         for (int m = 0; m < j; m++) begin
            idx = k + 1 - j + m;
            sb  = (idx < k) ? pattern[4'(len - 1 - idx)] : b;
            if (sb != pattern[4'(len - 1 - m)]) ok = 1'b0;
         end
         if (ok) best = j;
      end
      return best;
   endfunction
endpackage

// File: rtl/moore_seq_detector_counter.sv
// seq_hit_counter: saturating match-event counter where clear wins but still counts a coincident event.
module seq_hit_counter #(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_event,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= CNT_W'(i_event);
      else if (i_event && r_cnt != '1) r_cnt <= r_cnt + 1'b1;

   assign o_cnt = r_cnt;
endmodule

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore serial pattern detector driven by an elaboration-time KMP table.
module moore_seq_detector
   import moore_seq_pkg::*;
#(
   parameter int                     PAT_LEN = 3,
   parameter logic [MAX_PAT_LEN-1:0] PATTERN = '0,
   parameter bit                     OVERLAP = 1'b0,
   parameter int                     CNT_W   = 8
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_bit,
   input  logic                            in_valid,
   input  logic                            cnt_clr,
   output logic                            hit,
   output logic [clog2(PAT_LEN+1)-1:0]     state_o,
   output logic [CNT_W-1:0]                hit_cnt
);
   localparam int            SW     = clog2(PAT_LEN + 1);
   localparam logic [SW-1:0] S_FULL = SW'(PAT_LEN);

   if (PAT_LEN < 1 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
      $fatal(1, "moore_seq_detector: PAT_LEN %0d out of range", PAT_LEN);
   end
   if ((PATTERN >> PAT_LEN) != '0) begin : g_bad_pat
      $fatal(1, "moore_seq_detector: PATTERN wider than PAT_LEN");
   end

   logic [SW-1:0] w_tbl [0:PAT_LEN][0:1];
   logic [SW-1:0] r_state, w_sp, w_nxt;
   logic          w_illegal, w_event;

   for (genvar k = 0; k <= PAT_LEN; k++) begin : g_row
      for (genvar b = 0; b < 2; b++) begin : g_col
         assign w_tbl[k][b] = SW'(next_state(PATTERN, PAT_LEN, k, 1'(b)));
      end
   end

   // Without overlap a full match restarts from the empty prefix.
   assign w_illegal = r_state > S_FULL;
   assign w_sp      = (r_state == S_FULL && !OVERLAP) ? '0 : r_state;
   assign w_nxt     = w_illegal ? '0 : w_tbl[w_sp][in_bit];
   assign w_event   = in_valid && !w_illegal && w_nxt == S_FULL;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= '0;
      else if (in_valid || w_illegal) r_state <= w_nxt;

   assign hit     = r_state == S_FULL;
   assign state_o = r_state;

   seq_hit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_event (w_event),
      .i_clr   (cnt_clr),
      .o_cnt   (hit_cnt)
   );
endmodule

// File: tb/tb_moore_seq_detector.sv
// tb_moore_seq_detector: directed vectors over several parameterisations sharing one input stream.
module tb_moore_seq_detector;
   logic clk = 1'b0, rst_n = 1'b0, in_bit = 1'b0, in_valid = 1'b0, cnt_clr = 1'b0;
   logic       h0, h1, h2, h3, h4;
   logic [1:0] s0, s1, s4;
   logic [2:0] s2, s3;
   logic [7:0] c0, c1, c2, c3;
   logic [1:0] c4;
   int n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   moore_seq_detector d0 (.clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .hit(h0), .state_o(s0), .hit_cnt(c0));
   moore_seq_detector #(.OVERLAP(1'b1)) d1 (.clk(clk), .rst_n(rst_n), .in_bit(in_bit),
      .in_valid(in_valid), .cnt_clr(cnt_clr), .hit(h1), .state_o(s1), .hit_cnt(c1));
   moore_seq_detector #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b1)) d2 (.clk(clk),
      .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .cnt_clr(cnt_clr), .hit(h2),
      .state_o(s2), .hit_cnt(c2));
   moore_seq_detector #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b0)) d3 (.clk(clk),
      .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .cnt_clr(cnt_clr), .hit(h3),
      .state_o(s3), .hit_cnt(c3));
   moore_seq_detector #(.OVERLAP(1'b1), .CNT_W(2)) d4 (.clk(clk), .rst_n(rst_n),
      .in_bit(in_bit), .in_valid(in_valid), .cnt_clr(cnt_clr), .hit(h4), .state_o(s4),
      .hit_cnt(c4));

   typedef struct {
      int b, v, c;
      int s0, c0, s1, c1, c4;
   } vec_t;
   vec_t tv [12];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(input logic b, input logic v, input logic c);
      in_bit = b; in_valid = v; cnt_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int e2 [7];
      int e3 [7];
      int e4 [6];
      logic [6:0] bits3;
      logic [5:0] bits4;
      tv = '{
         '{0,1,0, 1,0, 1,0, 0}, '{0,1,0, 2,0, 2,0, 0}, '{0,1,0, 3,1, 3,1, 1},
         '{0,1,0, 1,1, 3,2, 2}, '{0,1,0, 2,1, 3,3, 3}, '{0,1,0, 3,2, 3,4, 3},
         '{0,1,0, 1,2, 3,5, 3}, '{0,1,1, 2,0, 3,1, 1}, '{1,0,1, 2,0, 3,0, 0},
         '{0,1,0, 3,1, 3,1, 1}, '{0,1,0, 1,1, 3,2, 2}, '{0,1,0, 2,1, 3,3, 3}};
      e2 = '{1,2,3,4,2,3,4};
      e3 = '{1,2,3,4,0,1,1};
      e4 = '{1,2,0,1,2,3};
      bits3 = 7'b1011011;
      bits4 = 6'b001000;

      #12;
      chk("rst_s0", s0, 0); chk("rst_h0", h0, 0); chk("rst_c0", c0, 0);
      chk("rst_s2", s2, 0); chk("rst_c4", c4, 0);
      rst_n = 1'b1;

      // zero stream, overlap vs restart, saturation and clear
      for (int i = 0; i < 12; i++) begin
         step(1'(tv[i].b), 1'(tv[i].v), 1'(tv[i].c));
         chk($sformatf("v%0d_s0", i), s0, tv[i].s0);
         chk($sformatf("v%0d_h0", i), h0, int'(tv[i].s0 == 3));
         chk($sformatf("v%0d_c0", i), c0, tv[i].c0);
         chk($sformatf("v%0d_s1", i), s1, tv[i].s1);
         chk($sformatf("v%0d_h1", i), h1, int'(tv[i].s1 == 3));
         chk($sformatf("v%0d_c1", i), c1, tv[i].c1);
         chk($sformatf("v%0d_c4", i), c4, tv[i].c4);
      end

      // asynchronous reset mid-cycle with d0 at s=2
      #2 rst_n = 1'b0;
      #1;
      chk("arst_s0", s0, 0); chk("arst_h1", h1, 0); chk("arst_c0", c0, 0);
      chk("arst_c1", c1, 0); chk("arst_c4", c4, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("post_s0_%0d", i), s0, i + 1);
      end
      chk("post_h0", h0, 1); chk("post_c0", c0, 1);

      // valid gap holds partial progress
      pulse_reset();
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0);
         chk($sformatf("gap_s0_%0d", i), s0, 2);
         chk($sformatf("gap_h0_%0d", i), h0, 0);
      end
      step(1'b0, 1'b1, 1'b0);
      chk("gap_end_s0", s0, 3); chk("gap_end_h0", h0, 1); chk("gap_end_c0", c0, 1);
      for (int i = 0; i < 6; i++) begin
         step(bits4[5-i], 1'b1, 1'b0);
         chk($sformatf("brk_s0_%0d", i), s0, e4[i]);
      end
      chk("brk_c0", c0, 2);

      // self-overlapping 1011 with and without overlap
      pulse_reset();
      for (int i = 0; i < 7; i++) begin
         step(bits3[6-i], 1'b1, 1'b0);
         chk($sformatf("p_s2_%0d", i), s2, e2[i]);
         chk($sformatf("p_h2_%0d", i), h2, int'(e2[i] == 4));
         chk($sformatf("p_s3_%0d", i), s3, e3[i]);
      end
      chk("p_c2", c2, 2); chk("p_c3", c3, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
